soc_riscv_jtag_tap_sampled: RTL and testbench

SOC_RISCV_JTAG_TAP_SAMPLED -- requirements
Module: soc_riscv_jtag_tap_sampled

---
 rtl/soc_riscv_jtag_pkg.sv | 59 +++++
 rtl/soc_riscv_jtag_sync.sv | 26 ++
 rtl/soc_riscv_jtag_tap_sampled.sv | 165 ++++++++++++++++
 tb/tb_soc_riscv_jtag_tap_sampled.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_riscv_jtag_pkg.sv
// Shared TAP state encodings, instruction codes and the TAP next-state function.
// The IDCODE instruction is present only when SOC_RISCV_JTAG_IDCODE_EN is defined.
package soc_riscv_jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  localparam logic [4:0] INSTR_IDCODE = 5'h01;
  localparam logic [4:0] INSTR_USER   = 5'h11;
  localparam logic [4:0] INSTR_BYPASS = 5'h1F;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_RESET;
    case (s)
      TAP_RESET:      n = tms ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  n = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        n = TAP_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/soc_riscv_jtag_sync.sv
// Two-flop synchronizer bank bringing asynchronous JTAG pins into the HCLK domain.
module soc_riscv_jtag_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/soc_riscv_jtag_tap_sampled.sv
// IEEE 1149.1 TAP oversampled on HCLK: TCK edges are detected from synchronized pins.
// Define SOC_RISCV_JTAG_IDCODE_EN to enable the IDCODE instruction (else it decodes as BYPASS).
module soc_riscv_jtag_tap_sampled
  import soc_riscv_jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 5,
  parameter int unsigned DR_WIDTH     = 32,
  parameter logic [31:0] IDCODE_VALUE = 32'h10001FFF
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                TRSTN,
  output logic                TDO,
  input  logic [DR_WIDTH-1:0] user_capture_data,
  output logic                user_update_valid,
  output logic [DR_WIDTH-1:0] user_update_data,
  output logic [3:0]          tap_state
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef SOC_RISCV_JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = '1;
`endif

  logic tck_s, tms_s, tdi_s, trst_n_s;

  soc_riscv_jtag_sync #(.WIDTH(4)) u_sync (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .d_i    ({TRSTN, TDI, TMS, TCK}),
    .q_o    ({trst_n_s, tdi_s, tms_s, tck_s})
  );

  tap_state_t          state_q, state_d, state_nx;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic                byp_q, byp_d;
  logic                tdo_q, tdo_d;
  logic                tck_prev_q;
  logic                upd_valid_q, upd_valid_d;
  logic [DR_WIDTH-1:0] upd_data_q, upd_data_d;
  logic                tck_rise, tck_fall;
  dr_sel_t             dr_sel;
  logic                dr_lsb;

  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;
  assign state_nx = tap_next(state_q, tms_s);

  always_comb begin
    dr_sel = DR_BYPASS;
`ifdef SOC_RISCV_JTAG_IDCODE_EN
    if (instr_q == IR_IDCODE) dr_sel = DR_IDCODE;
`endif
    if (instr_q == IR_USER) dr_sel = DR_USER;
  end

  always_comb begin
    dr_lsb = byp_q;
    case (dr_sel)
      DR_IDCODE: dr_lsb = id_sr_q[0];
      DR_USER:   dr_lsb = user_sr_q[0];
      default:   dr_lsb = byp_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ir_sr_d     = ir_sr_q;
    id_sr_d     = id_sr_q;
    user_sr_d   = user_sr_q;
    byp_d       = byp_q;
    tdo_d       = tdo_q;
    upd_valid_d = 1'b0;
    upd_data_d  = upd_data_q;

    // Shift uses the state being left, capture/update the state being entered;
    // the two never coincide, so leaving Shift still shifts one last bit.
    if (tck_rise && !tck_fall) begin
      state_d = state_nx;
      if (state_q == TAP_SHIFT_IR) ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
      if (state_q == TAP_SHIFT_DR) begin
        case (dr_sel)
          DR_IDCODE: id_sr_d   = {tdi_s, id_sr_q[31:1]};
          DR_USER:   user_sr_d = {tdi_s, user_sr_q[DR_WIDTH-1:1]};
          default:   byp_d     = tdi_s;
        endcase
      end
      case (state_nx)
        TAP_CAPTURE_IR: ir_sr_d = IR_CAPTURE;
        TAP_CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: id_sr_d   = IDCODE_VALUE;
            DR_USER:   user_sr_d = user_capture_data;
            default:   byp_d     = 1'b0;
          endcase
        end
        TAP_UPDATE_IR: instr_d = ir_sr_q;
        TAP_UPDATE_DR: begin
          if (dr_sel == DR_USER) begin
            upd_valid_d = 1'b1;
            upd_data_d  = user_sr_q;
          end
        end
        TAP_RESET: instr_d = IR_DEFAULT;
        default: ;
      endcase
    end

    if (tck_fall && !tck_rise) begin
      tdo_d = 1'b0;
      if (state_q == TAP_SHIFT_IR) tdo_d = ir_sr_q[0];
      if (state_q == TAP_SHIFT_DR) tdo_d = dr_lsb;
    end

    if (!trst_n_s) begin
      state_d     = TAP_RESET;
      instr_d     = IR_DEFAULT;
      upd_valid_d = 1'b0;
      upd_data_d  = upd_data_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= TAP_RESET;
      instr_q     <= IR_DEFAULT;
      ir_sr_q     <= '0;
      id_sr_q     <= '0;
      user_sr_q   <= '0;
      byp_q       <= 1'b0;
      tdo_q       <= 1'b0;
      tck_prev_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      ir_sr_q     <= ir_sr_d;
      id_sr_q     <= id_sr_d;
      user_sr_q   <= user_sr_d;
      byp_q       <= byp_d;
      tdo_q       <= tdo_d;
      tck_prev_q  <= tck_s;
      upd_valid_q <= upd_valid_d;
      upd_data_q  <= upd_data_d;
    end
  end

  assign TDO               = tdo_q;
  assign user_update_valid = upd_valid_q;
  assign user_update_data  = upd_data_q;
  assign tap_state         = state_q;

endmodule

// File: tb/tb_soc_riscv_jtag_tap_sampled.sv
// Bench for soc_riscv_jtag_tap_sampled: bit-banged JTAG host plus a transaction-level model.
// Expectations follow SOC_RISCV_JTAG_IDCODE_EN the same way the design does.
module tb_soc_riscv_jtag_tap_sampled;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        TCK = 1'b0, TMS = 1'b1, TDI = 1'b0, TRSTN = 1'b1;
  logic        TDO;
  logic [31:0] user_capture_data = 32'h0;
  logic        user_update_valid;
  logic [31:0] user_update_data;
  logic [3:0]  tap_state;

  int n_tests = 0;
  int n_fail  = 0;

  int          hi_cnt = 0, rise_cnt = 0;
  logic        prev_v = 1'b0;
  logic [31:0] last_upd = 32'h0;
  logic [4:0]  m_instr;

  localparam logic [31:0] IDCODE = 32'h10001FFF;
`ifdef SOC_RISCV_JTAG_IDCODE_EN
  localparam logic [4:0] DEF_INSTR = 5'h01;
  localparam bit         ID_EN = 1'b1;
`else
  localparam logic [4:0] DEF_INSTR = 5'h1F;
  localparam bit         ID_EN = 1'b0;
`endif

  soc_riscv_jtag_tap_sampled dut (
    .HCLK              (HCLK),
    .HRESETn           (HRESETn),
    .TCK               (TCK),
    .TMS               (TMS),
    .TDI               (TDI),
    .TRSTN             (TRSTN),
    .TDO               (TDO),
    .user_capture_data (user_capture_data),
    .user_update_valid (user_update_valid),
    .user_update_data  (user_update_data),
    .tap_state         (tap_state)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (user_update_valid) begin
      hi_cnt = hi_cnt + 1;
      last_upd = user_update_data;
      if (!prev_v) rise_cnt = rise_cnt + 1;
    end
    prev_v = user_update_valid;
  end

  function automatic logic [31:0] mask_n(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic bit is_user(input logic [4:0] ins);
    return ins == 5'h11;
  endfunction

  function automatic bit is_id(input logic [4:0] ins);
    return ID_EN && (ins == 5'h01);
  endfunction

  // What the host reads back from an n-bit DR scan under instruction ins.
  function automatic logic [31:0] exp_tdo(input logic [4:0] ins, input logic [31:0] cap,
                                          input logic [31:0] d, input int n);
    if (is_user(ins)) return cap & mask_n(n);
    if (is_id(ins))   return IDCODE & mask_n(n);
    return (d << 1) & mask_n(n);
  endfunction

  // Contents of the 32-bit user register after shifting n bits of d into captured cap.
  function automatic logic [31:0] exp_upd(input logic [31:0] cap, input logic [31:0] d, input int n);
    logic [63:0] t;
    t = ({32'h0, cap} >> n) | ({32'h0, d & mask_n(n)} << (32 - n));
    return t[31:0];
  endfunction

  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    @(negedge HCLK); TMS = tms; TDI = tdi;
    repeat (5) @(negedge HCLK); TCK = 1'b1;
    repeat (6) @(negedge HCLK); TCK = 1'b0;
    repeat (6) @(negedge HCLK); tdo = TDO;
  endtask

  // Both scans start and end in Run-Test/Idle.
  task automatic shift_ir(input logic [4:0] v, output logic [4:0] out);
    logic t;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    out[0] = t;
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], t);
      if (i < 4) out[i+1] = t;
    end
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    m_instr = v;
  endtask

  task automatic shift_dr(input logic [31:0] d, input int n, output logic [31:0] out);
    logic t;
    out = 32'h0;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    out[0] = t;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, d[i], t);
      if (i < n - 1) out[i+1] = t;
    end
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic test_reset();
    logic [31:0] o, d;
    logic t;
    HRESETn = 1'b0;
    repeat (4) @(negedge HCLK);
    n_tests++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL reset_state got %h want f", tap_state); end
    n_tests++; if (TDO !== 1'b0) begin n_fail++; $display("FAIL reset_tdo got %b want 0", TDO); end
    n_tests++; if (user_update_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", user_update_valid); end
    n_tests++; if (user_update_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", user_update_data); end
    HRESETn = 1'b1;
    m_instr = DEF_INSTR;
    repeat (4) @(negedge HCLK);
    tck_cycle(1'b0, 1'b0, t);
    d = $urandom;
    shift_dr(d, 32, o);
    n_tests++; if (o !== exp_tdo(m_instr, 32'h0, d, 32)) begin
      n_fail++; $display("FAIL reset_dr_scan got %h want %h", o, exp_tdo(m_instr, 32'h0, d, 32)); end
  endtask

  task automatic test_user();
    logic [4:0] ir;
    logic [31:0] o;
    int h0, r0;
    shift_ir(5'h11, ir);
    user_capture_data = 32'hDEADBEEF;
    h0 = hi_cnt; r0 = rise_cnt;
    shift_dr(32'h12345678, 32, o);
    n_tests++; if (o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL user_tdo got %h want deadbeef", o); end
    n_tests++; if (rise_cnt - r0 != 1 || hi_cnt - h0 != 1) begin
      n_fail++; $display("FAIL user_pulse got pulses=%0d cycles=%0d want 1/1", rise_cnt - r0, hi_cnt - h0); end
    n_tests++; if (last_upd !== 32'h12345678) begin n_fail++; $display("FAIL user_upd_data got %h want 12345678", last_upd); end
  endtask

  task automatic test_bypass();
    logic [4:0] ir;
    logic [31:0] o;
    int h0;
    shift_ir(5'h1F, ir);
    h0 = hi_cnt;
    shift_dr(32'hA5, 8, o);
    n_tests++; if (o[7:0] !== 8'h4A) begin n_fail++; $display("FAIL bypass_tdo got %h want 4a", o[7:0]); end
    n_tests++; if (hi_cnt != h0) begin n_fail++; $display("FAIL bypass_no_pulse got %0d want 0", hi_cnt - h0); end
  endtask

  task automatic test_trst_abort();
    logic [4:0] ir;
    logic [31:0] o, d;
    logic t;
    int h0;
    shift_ir(5'h11, ir);
    h0 = hi_cnt;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    repeat (3) tck_cycle(1'b0, 1'b1, t);
    @(negedge HCLK); TRSTN = 1'b0;
    repeat (8) @(negedge HCLK); TRSTN = 1'b1;
    repeat (6) @(negedge HCLK);
    m_instr = DEF_INSTR;
    n_tests++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL trst_state got %h want f", tap_state); end
    tck_cycle(1'b0, 1'b0, t);
    d = $urandom;
    shift_dr(d, 32, o);
    n_tests++; if (hi_cnt != h0) begin n_fail++; $display("FAIL trst_no_pulse got %0d want 0", hi_cnt - h0); end
    n_tests++; if (o !== exp_tdo(m_instr, user_capture_data, d, 32)) begin
      n_fail++; $display("FAIL trst_instr got %h want %h", o, exp_tdo(m_instr, user_capture_data, d, 32)); end
  endtask

  task automatic test_tlr_from_shift_ir();
    logic [4:0] ir;
    logic t;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    repeat (5) tck_cycle(1'b1, 1'b0, t);
    m_instr = DEF_INSTR;
    n_tests++; if (tap_state !== 4'hF) begin n_fail++; $display("FAIL tms5_state got %h want f", tap_state); end
    tck_cycle(1'b0, 1'b0, t);
    shift_ir(5'(($urandom_range(0, 1) != 0) ? 5'h11 : 5'h1F), ir);
    n_tests++; if (ir !== 5'b00001) begin n_fail++; $display("FAIL tms5_ir_capture got %b want 00001", ir); end
  endtask

  task automatic test_tdo_latency();
    logic t;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    @(negedge HCLK); TMS = 1'b0; TDI = 1'b1;
    repeat (5) @(negedge HCLK); TCK = 1'b1;
    repeat (6) @(negedge HCLK); TCK = 1'b0;
    @(posedge HCLK); @(posedge HCLK); #1;
    n_tests++; if (TDO !== 1'b0) begin n_fail++; $display("FAIL tdo_lat_early got %b want 0", TDO); end
    @(posedge HCLK); #1;
    n_tests++; if (TDO !== 1'b1) begin n_fail++; $display("FAIL tdo_lat_third got %b want 1", TDO); end
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, 1'b1, t);
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    m_instr = 5'h1F;
  endtask

  task automatic test_hreset_abort();
    logic [4:0] ir;
    logic t;
    int h0;
    shift_ir(5'h11, ir);
    h0 = hi_cnt;
    tck_cycle(1'b1, 1'b0, t); tck_cycle(1'b0, 1'b0, t); tck_cycle(1'b0, 1'b0, t);
    repeat (4) tck_cycle(1'b0, 1'b1, t);
    @(negedge HCLK); HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    n_tests++; if (tap_state !== 4'hF || user_update_data !== 32'h0) begin
      n_fail++; $display("FAIL hreset_abort got state=%h data=%h want f/0", tap_state, user_update_data); end
    HRESETn = 1'b1;
    m_instr = DEF_INSTR;
    repeat (4) @(negedge HCLK);
    tck_cycle(1'b0, 1'b0, t);
    n_tests++; if (hi_cnt != h0) begin n_fail++; $display("FAIL hreset_no_pulse got %0d want 0", hi_cnt - h0); end
  endtask

  task automatic test_random();
    logic [4:0]  ir, ins;
    logic [31:0] o, d, cap;
    int n, h0, r0;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0:       ins = 5'h01;
        1:       ins = 5'h11;
        2:       ins = 5'h1F;
        default: ins = 5'($urandom);
      endcase
      shift_ir(ins, ir);
      n_tests++; if (ir !== 5'b00001) begin n_fail++; $display("FAIL rnd_ir_capture[%0d] got %b want 00001", k, ir); end
      cap = $urandom; d = $urandom; n = $urandom_range(1, 32);
      user_capture_data = cap;
      h0 = hi_cnt; r0 = rise_cnt;
      shift_dr(d, n, o);
      n_tests++; if (o !== exp_tdo(m_instr, cap, d, n)) begin
        n_fail++; $display("FAIL rnd_tdo[%0d] ins=%h n=%0d got %h want %h", k, m_instr, n, o, exp_tdo(m_instr, cap, d, n)); end
      n_tests++; if (rise_cnt - r0 != int'(is_user(m_instr)) || hi_cnt - h0 != int'(is_user(m_instr))) begin
        n_fail++; $display("FAIL rnd_pulse[%0d] got %0d/%0d want %0d", k, rise_cnt - r0, hi_cnt - h0, int'(is_user(m_instr))); end
      if (is_user(m_instr)) begin
        n_tests++; if (last_upd !== exp_upd(cap, d, n)) begin
          n_fail++; $display("FAIL rnd_upd[%0d] n=%0d got %h want %h", k, n, last_upd, exp_upd(cap, d, n)); end
      end
    end
  endtask

  initial begin
    m_instr = DEF_INSTR;
    test_reset();
    test_user();
    test_bypass();
    test_trst_abort();
    test_tlr_from_shift_ir();
    test_tdo_latency();
    test_hreset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
